// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared types and distance helper for the two-circle cover engine
package laser_pkg;

   // Widest coordinate the shared point type can carry; narrower grids zero-extend into it.
   localparam int MAX_COORD_W = 8;
   localparam int D2_W        = 2 * MAX_COORD_W + 2;

   typedef logic [MAX_COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } point_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PASS0,
      S_PASSK,
      S_FINISH
   } state_e;

   // Squared Euclidean distance. Coordinates are zero-extended before the signed
   // subtraction, so the result equals the narrow COORD_W+1 bit arithmetic exactly.
   function automatic logic [D2_W-1:0] dist2(point_t a, point_t b);
      logic signed [D2_W-1:0] dx;
      logic signed [D2_W-1:0] dy;
      logic [D2_W-1:0]        sx;
      logic [D2_W-1:0]        sy;
      dx = $signed({{(D2_W-MAX_COORD_W){1'b0}}, a.x}) - $signed({{(D2_W-MAX_COORD_W){1'b0}}, b.x});
      dy = $signed({{(D2_W-MAX_COORD_W){1'b0}}, a.y}) - $signed({{(D2_W-MAX_COORD_W){1'b0}}, b.y});
      sx = dx * dx;
      sy = dy * dy;
      return sx + sy;
   endfunction

endpackage

// File: rtl/laser_lane_count.sv
// rtl/laser_lane_count.sv - combinational count of points covered by candidate or fixed circle
module laser_lane_count
   import laser_pkg::*;
#(
   parameter int LANES = 1,
   parameter int CW    = 6,
   parameter int R2    = 16
)(
   input  point_t         cand,
   input  point_t         fix_pt,
   input  logic           fix_valid,
   input  point_t         pts [LANES],
   output logic [CW-1:0]  count
);

   localparam logic [D2_W-1:0] R2_L = D2_W'(R2);

   // Add one per lane whose point lies inside the candidate or the (valid) fixed circle.
   always_comb begin
      count = '0;
      for (int l = 0; l < LANES; l++) begin
         if ((dist2(cand, pts[l]) <= R2_L) ||
             (fix_valid && (dist2(fix_pt, pts[l]) <= R2_L))) begin
            count = count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/laser_cover_engine.sv
// rtl/laser_cover_engine.sv - point loader, alternating grid search and result registers
module laser_cover_engine #(
   parameter int COORD_W  = 4,
   parameter int N_PTS    = 40,
   parameter int R2       = 16,
   parameter int LANES    = 1,
   parameter int MAX_PASS = 8
)(
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [COORD_W-1:0]           X,
   input  logic [COORD_W-1:0]           Y,
   input  logic                         IN_VALID,
   output logic [COORD_W-1:0]           C1X,
   output logic [COORD_W-1:0]           C1Y,
   output logic [COORD_W-1:0]           C2X,
   output logic [COORD_W-1:0]           C2Y,
   output logic [$clog2(N_PTS+1)-1:0]   COVER,
   output logic                         BUSY,
   output logic                         DONE
);
   import laser_pkg::*;

   localparam int CW     = $clog2(N_PTS + 1);
   localparam int GROUPS = N_PTS / LANES;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int IW     = (N_PTS > 1) ? $clog2(N_PTS) : 1;
   localparam int PW     = $clog2(MAX_PASS + 1);

   if (N_PTS % LANES != 0) begin : g_bad_lanes
      $error("laser_cover_engine: N_PTS must be a multiple of LANES");
   end
   if (COORD_W > MAX_COORD_W) begin : g_bad_coord
      $error("laser_cover_engine: COORD_W exceeds MAX_COORD_W");
   end

   state_e               state, state_nxt;
   point_t               pts [N_PTS];
   point_t               lane_pts [LANES];
   logic [IW-1:0]        cnt;
   logic [COORD_W-1:0]   cand_x, cand_y;
   logic [GW-1:0]        grp;
   logic [CW-1:0]        acc, best, lane_cnt, sum;
   logic [COORD_W-1:0]   w1x, w1y, w2x, w2y;
   logic [PW-1:0]        pass;
   logic                 moved;

   logic accept, load_last, searching, tgt_c2, last_grp, last_cand;
   logic pass_end, replace, stop;
   point_t cand_pt, fix_pt;

   assign accept    = ((state == S_IDLE) || (state == S_LOAD)) && IN_VALID;
   assign load_last = accept && (cnt == IW'(N_PTS - 1));
   assign searching = (state == S_PASS0) || (state == S_PASSK);
   // Odd refinement passes move C2; pass 0 and even passes move C1.
   assign tgt_c2    = (state == S_PASSK) && pass[0];
   assign last_grp  = (grp == GW'(GROUPS - 1));
   assign last_cand = (cand_x == '1) && (cand_y == '1);
   assign pass_end  = searching && last_grp && last_cand;
   assign sum       = acc + lane_cnt;
   // Pass 0 starts from best = -1, so its first candidate always wins; afterwards
   // best carries the union count of the current pair and only strict gains replace.
   assign replace   = searching && last_grp &&
                      (((state == S_PASS0) && (cand_x == '0) && (cand_y == '0)) || (sum > best));
   assign stop      = (state == S_PASSK) && (!(moved || replace) || (pass == PW'(MAX_PASS)));

   assign cand_pt = '{x: coord_t'(cand_x), y: coord_t'(cand_y)};
   assign fix_pt  = tgt_c2 ? '{x: coord_t'(w1x), y: coord_t'(w1y)}
                           : '{x: coord_t'(w2x), y: coord_t'(w2y)};

   // Select the LANES stored points belonging to the current group.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_pts[l] = pts[IW'(int'(grp) * LANES + l)];
      end
   end

   laser_lane_count #(
      .LANES (LANES),
      .CW    (CW),
      .R2    (R2)
   ) u_lane (
      .cand      (cand_pt),
      .fix_pt    (fix_pt),
      .fix_valid (state == S_PASSK),
      .pts       (lane_pts),
      .count     (lane_cnt)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = load_last ? S_PASS0 : S_LOAD;
         S_LOAD:   if (load_last) state_nxt = S_PASS0;
         S_PASS0:  if (pass_end) state_nxt = S_PASSK;
         S_PASSK:  if (pass_end && stop) state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Point storage; contents are don't-care until a full job has been loaded.
   always_ff @(posedge CLK) begin
      if (accept) pts[cnt] <= '{x: coord_t'(X), y: coord_t'(Y)};
   end

   // Load counter, scan counters, best tracker and registered results.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt    <= '0;
         cand_x <= '0;
         cand_y <= '0;
         grp    <= '0;
         acc    <= '0;
         best   <= '0;
         w1x    <= '0;
         w1y    <= '0;
         w2x    <= '0;
         w2y    <= '0;
         pass   <= '0;
         moved  <= 1'b0;
         C1X    <= '0;
         C1Y    <= '0;
         C2X    <= '0;
         C2Y    <= '0;
         COVER  <= '0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (accept) begin
            BUSY <= 1'b1;
            cnt  <= load_last ? '0 : cnt + IW'(1);
         end
         if (load_last) begin
            cand_x <= '0;
            cand_y <= '0;
            grp    <= '0;
            acc    <= '0;
            best   <= '0;
            w1x    <= '0;
            w1y    <= '0;
            w2x    <= '0;
            w2y    <= '0;
            pass   <= '0;
            moved  <= 1'b0;
         end
         if (searching) begin
            if (last_grp) begin
               grp <= '0;
               acc <= '0;
               if (replace) begin
                  best  <= sum;
                  moved <= 1'b1;
                  if (tgt_c2) begin
                     w2x <= cand_x;
                     w2y <= cand_y;
                  end else begin
                     w1x <= cand_x;
                     w1y <= cand_y;
                  end
               end
               cand_x <= cand_x + COORD_W'(1);
               if (cand_x == '1) cand_y <= cand_y + COORD_W'(1);
               if (pass_end) begin
                  moved <= 1'b0;
                  pass  <= (state == S_PASS0) ? PW'(1) : pass + PW'(1);
               end
            end else begin
               grp <= grp + GW'(1);
               acc <= sum;
            end
         end
         if (state == S_FINISH) begin
            C1X   <= w1x;
            C1Y   <= w1y;
            C2X   <= w2x;
            C2Y   <= w2y;
            COVER <= best;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_laser_cover_engine.sv
// tb/tb_laser_cover_engine.sv - scoreboard bench for three engine configurations
module tb_laser_cover_engine;

   typedef struct {
      logic [3:0] c1x, c1y, c2x, c2y;
      logic [5:0] cov;
      int         lat_min, lat_max;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_s  [3];
   logic [3:0] x_s    [3];
   logic [3:0] y_s    [3];
   logic       v_s    [3];
   logic [3:0] c1x_s  [3];
   logic [3:0] c1y_s  [3];
   logic [3:0] c2x_s  [3];
   logic [3:0] c2y_s  [3];
   logic [5:0] cov_s  [3];
   logic       busy_s [3];
   logic       done_s [3];

   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   last_cyc [3];
   exp_t q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   laser_cover_engine u_a (
      .CLK(clk), .RST(rst_s[0]), .X(x_s[0]), .Y(y_s[0]), .IN_VALID(v_s[0]),
      .C1X(c1x_s[0]), .C1Y(c1y_s[0]), .C2X(c2x_s[0]), .C2Y(c2y_s[0]),
      .COVER(cov_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0])
   );

   laser_cover_engine #(.LANES(4)) u_b (
      .CLK(clk), .RST(rst_s[1]), .X(x_s[1]), .Y(y_s[1]), .IN_VALID(v_s[1]),
      .C1X(c1x_s[1]), .C1Y(c1y_s[1]), .C2X(c2x_s[1]), .C2Y(c2y_s[1]),
      .COVER(cov_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1])
   );

   laser_cover_engine #(.LANES(4), .MAX_PASS(1)) u_c (
      .CLK(clk), .RST(rst_s[2]), .X(x_s[2]), .Y(y_s[2]), .IN_VALID(v_s[2]),
      .C1X(c1x_s[2]), .C1Y(c1y_s[2]), .C2X(c2x_s[2]), .C2Y(c2y_s[2]),
      .COVER(cov_s[2]), .BUSY(busy_s[2]), .DONE(done_s[2])
   );

   task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL inst%0d %s: got %0d, want %0d", k, name, act, req);
      end
   endtask

   function automatic logic [7:0] pt_of(input int pat, input int i);
      case (pat)
         0:       return 8'h55;
         1:       return (i < 20) ? 8'h22 : 8'hcc;
         default: return (i < 13) ? 8'h11 : ((i < 27) ? 8'h88 : 8'hee);
      endcase
   endfunction

   task automatic push_exp(input int k, input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y, input logic [5:0] cov,
                           input int lat_base);
      exp_t e;
      e.c1x = c1x; e.c1y = c1y; e.c2x = c2x; e.c2y = c2y; e.cov = cov;
      e.lat_min = lat_base;
      e.lat_max = lat_base + 4;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int k, output exp_t e, output bit ok);
      ok = 1'b1;
      e  = '{default: 0};
      case (k)
         0:       if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
         1:       if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
         default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic feed(input int k, input int pat, input bit toggle);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         {x_s[k], y_s[k]} = pt_of(pat, i);
         v_s[k] = 1'b1;
         if (i == 39) last_cyc[k] = cyc + 1;
         else if (toggle) begin
            @(negedge clk);
            v_s[k] = 1'b0;
            x_s[k] = 4'hf;
            y_s[k] = 4'hf;
         end
      end
      @(negedge clk);
      v_s[k] = 1'b0;
   endtask

   task automatic pulse_junk(input int k);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         x_s[k] = 4'hf;
         y_s[k] = 4'hf;
         v_s[k] = 1'b1;
      end
      @(negedge clk);
      v_s[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_s[k] && n < budget);
      chk(k, "done_within_budget", done_s[k], 1);
   endtask

   task automatic chk_zero(input int k, input string tag);
      chk(k, {tag, "_c1x"}, c1x_s[k], 0);
      chk(k, {tag, "_c1y"}, c1y_s[k], 0);
      chk(k, {tag, "_c2x"}, c2x_s[k], 0);
      chk(k, {tag, "_c2y"}, c2y_s[k], 0);
      chk(k, {tag, "_cover"}, cov_s[k], 0);
      chk(k, {tag, "_busy"}, busy_s[k], 0);
      chk(k, {tag, "_done"}, done_s[k], 0);
   endtask

   // Monitor: pops one expected result per DONE pulse and compares it.
   initial begin
      bit   prev_done [3];
      exp_t e;
      bit   ok;
      int   lat;
      for (int k = 0; k < 3; k++) prev_done[k] = 1'b0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (prev_done[k]) chk(k, "done_one_cycle", done_s[k], 0);
            if (done_s[k] === 1'b1) begin
               pop_exp(k, e, ok);
               if (!ok) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL inst%0d unexpected_done: got DONE, want no pending job", k);
               end else begin
                  chk(k, "c1x", c1x_s[k], e.c1x);
                  chk(k, "c1y", c1y_s[k], e.c1y);
                  chk(k, "c2x", c2x_s[k], e.c2x);
                  chk(k, "c2y", c2y_s[k], e.c2y);
                  chk(k, "cover", cov_s[k], e.cov);
                  chk(k, "busy_low_at_done", busy_s[k], 0);
                  lat = cyc - last_cyc[k];
                  n_vec++;
                  if (lat < e.lat_min || lat > e.lat_max) begin
                     n_bad++;
                     $display("FAIL inst%0d latency: got %0d, want %0d..%0d", k, lat, e.lat_min, e.lat_max);
                  end
               end
            end
            prev_done[k] = (done_s[k] === 1'b1);
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 80000 cycles");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_s[k] = 1'b0;
         x_s[k]   = '0;
         y_s[k]   = '0;
         v_s[k]   = 1'b0;
         last_cyc[k] = 0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) chk_zero(k, "reset");
      for (int k = 0; k < 3; k++) rst_s[k] = 1'b1;

      fork
         begin : seq_a
            push_exp(0, 4'd5, 4'd1, 4'd0, 4'd0, 6'd40, 2 * 256 * 40);
            feed(0, 0, 1'b0);
            chk(0, "busy_after_load", busy_s[0], 1);
            wait_done(0, 25000);
            @(negedge clk);
            chk(0, "busy_after_done", busy_s[0], 0);
            chk(0, "hold_c1y", c1y_s[0], 1);
            push_exp(0, 4'd0, 4'd0, 4'd12, 4'd8, 6'd40, 3 * 256 * 40);
            feed(0, 1, 1'b0);
            wait_done(0, 35000);
         end
         begin : seq_b
            push_exp(1, 4'd0, 4'd0, 4'd12, 4'd8, 6'd40, 3 * 256 * 10);
            feed(1, 1, 1'b0);
            wait_done(1, 9000);
            push_exp(1, 4'd0, 4'd0, 4'd12, 4'd8, 6'd40, 3 * 256 * 10);
            feed(1, 1, 1'b1);
            repeat (100) @(negedge clk);
            pulse_junk(1);
            repeat (3000) @(negedge clk);
            pulse_junk(1);
            wait_done(1, 9000);
            feed(1, 2, 1'b0);
            repeat (3000) @(negedge clk);
            chk(1, "busy_mid_search", busy_s[1], 1);
            chk(1, "hold_c2x", c2x_s[1], 12);
            #2 rst_s[1] = 1'b0;
            #1 chk_zero(1, "abort");
            @(negedge clk);
            rst_s[1] = 1'b1;
            push_exp(1, 4'd5, 4'd1, 4'd0, 4'd0, 6'd40, 2 * 256 * 10);
            feed(1, 0, 1'b0);
            wait_done(1, 6000);
         end
         begin : seq_c
            push_exp(2, 4'd8, 4'd4, 4'd0, 4'd0, 6'd27, 2 * 256 * 10);
            feed(2, 2, 1'b0);
            wait_done(2, 7000);
         end
      join

      repeat (5) @(negedge clk);
      for (int k = 0; k < 3; k++) chk(k, "pending_results", q_size(k), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
